// File: rtl/aes_pkg.sv
// Shared AES package used by the pipelined encryptor and decryptor.
// Provides the forward/inverse S-box tables, the Rcon table, the GF(2^8)
// helpers (polynomial 0x11B), the 16-byte state type and the key-FSM state
// enum. Byte 0 of a block is the most significant byte ([127:120]), which
// is what the ascending packed range of state_t gives directly.
package aes_pkg;

    localparam int AES128_NR = 10;

    typedef logic [0:15][7:0] state_t;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_EXPAND,
        KEY_READY
    } key_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Index 0 is unused; round i of the key schedule uses RCON[i].
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_dec_full_pipeline_if.sv
// Bus interface of the pipelined AES-128 decryptor.
// master: block/key source and plaintext sink (drives IN, KEY, enable, fsm_en).
// slave : the decryptor (drives OUT, valid_out, key_ready).
// With AES_DEC_DROP_FLAG_EN defined the slave also drives drop_err.
interface aes_dec_full_pipeline_if;
    logic [127:0] IN;
    logic [127:0] KEY;
    logic         enable;
    logic         fsm_en;
    logic [127:0] OUT;
    logic         valid_out;
    logic         key_ready;
`ifdef AES_DEC_DROP_FLAG_EN
    logic         drop_err;

    modport master (output IN, KEY, enable, fsm_en,
                    input  OUT, valid_out, key_ready, drop_err);
    modport slave  (input  IN, KEY, enable, fsm_en,
                    output OUT, valid_out, key_ready, drop_err);
`else
    modport master (output IN, KEY, enable, fsm_en,
                    input  OUT, valid_out, key_ready);
    modport slave  (input  IN, KEY, enable, fsm_en,
                    output OUT, valid_out, key_ready);
`endif
endinterface

// File: rtl/aes_dec_round.sv
// Combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// Ports: din (state in), rkey (round key), last_round (1 = skip
// InvMixColumns, used for the final round), dout (state out).
module aes_dec_round
    import aes_pkg::*;
(
    input  state_t       din,
    input  logic [127:0] rkey,
    input  logic         last_round,
    output state_t       dout
);

    state_t isr;
    state_t isb;
    state_t ark;
    state_t imc;

    always_comb begin
        isr = '0;
        isb = '0;
        imc = '0;
        // Byte index = 4*column + row; row r is rotated right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[4*c + r] = din[4*((c - r + 4) % 4) + r];
            end
        end
        for (int b = 0; b < 16; b++) begin
            isb[b] = INV_SBOX[isr[b]];
        end
        ark = isb ^ rkey;
        for (int c = 0; c < 4; c++) begin
            imc[4*c + 0] = gmul(ark[4*c], 8'h0e) ^ gmul(ark[4*c+1], 8'h0b)
                         ^ gmul(ark[4*c+2], 8'h0d) ^ gmul(ark[4*c+3], 8'h09);
            imc[4*c + 1] = gmul(ark[4*c], 8'h09) ^ gmul(ark[4*c+1], 8'h0e)
                         ^ gmul(ark[4*c+2], 8'h0b) ^ gmul(ark[4*c+3], 8'h0d);
            imc[4*c + 2] = gmul(ark[4*c], 8'h0d) ^ gmul(ark[4*c+1], 8'h09)
                         ^ gmul(ark[4*c+2], 8'h0e) ^ gmul(ark[4*c+3], 8'h0b);
            imc[4*c + 3] = gmul(ark[4*c], 8'h0b) ^ gmul(ark[4*c+1], 8'h0d)
                         ^ gmul(ark[4*c+2], 8'h09) ^ gmul(ark[4*c+3], 8'h0e);
        end
        dout = last_round ? ark : imc;
    end

endmodule

// File: rtl/aes_dec_full_pipeline.sv
// Fully pipelined AES-128 inverse cipher, one block per cycle.
// Ports: clk, rst (async, active high), bus (aes_dec_full_pipeline_if.slave):
//   IN/enable   ciphertext block and its qualifier
//   KEY/fsm_en  cipher key, sampled on the fsm_en pulse that starts expansion
//   OUT/valid_out plaintext and its qualifier (OUT holds when not valid)
//   key_ready   round keys complete; blocks are only accepted while high
// Optional macro AES_DEC_DROP_FLAG_EN adds bus.drop_err, a sticky flag set
// when a block is offered while key_ready is low.
// Pipeline: stage 0 = IN ^ rk[10]; rounds 1..10 each use rk[10-s]; the last
// round result lands in OUT, giving 11 register stages.
module aes_dec_full_pipeline
    import aes_pkg::*;
#(
    parameter int NR          = AES128_NR,
    parameter int PIPE_STAGES = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_dec_full_pipeline_if.slave bus
);

    key_state_t state_q;
    key_state_t state_d;
    logic       start;
    logic [3:0] rnd_q;
    logic       key_ready_q;

    logic [127:0] rk [0:NR];
    logic [127:0] rk_prev;
    logic [127:0] rk_next;
    logic [31:0]  rot_w;
    logic [31:0]  tmp_w;
    logic [31:0]  w0_n;
    logic [31:0]  w1_n;
    logic [31:0]  w2_n;
    logic [31:0]  w3_n;

    logic [PIPE_STAGES-1:0] vld_q;
    state_t                 stage_q [0:PIPE_STAGES-2];
    state_t                 round_out [1:NR];
    state_t                 out_q;
    logic                   accept;

    // fsm_en is ignored during expansion, so a start can only come from
    // IDLE or READY.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            KEY_IDLE: begin
                if (bus.fsm_en) begin
                    start   = 1'b1;
                    state_d = KEY_EXPAND;
                end
            end
            KEY_EXPAND: begin
                if (rnd_q == 4'(NR)) state_d = KEY_READY;
            end
            KEY_READY: begin
                if (bus.fsm_en) begin
                    start   = 1'b1;
                    state_d = KEY_EXPAND;
                end
            end
            default: state_d = KEY_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= KEY_IDLE;
        else     state_q <= state_d;
    end

    // One key-schedule step per cycle: rk[rnd] from rk[rnd-1].
    always_comb begin
        rk_prev = rk[0];
        for (int i = 1; i <= NR; i++) begin
            if (rnd_q == 4'(i)) rk_prev = rk[i-1];
        end
        rot_w = {rk_prev[23:0], rk_prev[31:24]};
        tmp_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                 SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]}
              ^ {RCON[rnd_q], 24'h000000};
        w0_n    = rk_prev[127:96] ^ tmp_w;
        w1_n    = rk_prev[95:64]  ^ w0_n;
        w2_n    = rk_prev[63:32]  ^ w1_n;
        w3_n    = rk_prev[31:0]   ^ w2_n;
        rk_next = {w0_n, w1_n, w2_n, w3_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q       <= 4'd1;
            key_ready_q <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            // Registered one cycle after entering READY; drops on a restart.
            key_ready_q <= (state_q == KEY_READY) && !start;
            if (start) begin
                rk[0] <= bus.KEY;
                rnd_q <= 4'd1;
            end else if (state_q == KEY_EXPAND) begin
                for (int i = 1; i <= NR; i++) begin
                    if (rnd_q == 4'(i)) rk[i] <= rk_next;
                end
                rnd_q <= (rnd_q == 4'(NR)) ? 4'd1 : rnd_q + 4'd1;
            end
        end
    end

    for (genvar s = 1; s <= NR; s++) begin : g_round
        aes_dec_round u_round (
            .din        (stage_q[s-1]),
            .rkey       (rk[NR-s]),
            .last_round (s == NR),
            .dout       (round_out[s])
        );
    end

    assign accept = bus.enable && key_ready_q;

    // Data registers advance every cycle; only the valid bits qualify them.
    // A restart flushes every valid bit so in-flight blocks never surface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            out_q <= '0;
            for (int s = 0; s < PIPE_STAGES - 1; s++) stage_q[s] <= '0;
        end else begin
            stage_q[0] <= bus.IN ^ rk[NR];
            for (int s = 1; s < PIPE_STAGES - 1; s++) stage_q[s] <= round_out[s];
            if (vld_q[PIPE_STAGES-2] && !start) out_q <= round_out[NR];
            if (start) vld_q <= '0;
            else       vld_q <= {vld_q[PIPE_STAGES-2:0], accept};
        end
    end

    assign bus.OUT       = out_q;
    assign bus.valid_out = vld_q[PIPE_STAGES-1];
    assign bus.key_ready = key_ready_q;

`ifdef AES_DEC_DROP_FLAG_EN
    logic drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              drop_q <= 1'b0;
        else if (start)                       drop_q <= 1'b0;
        else if (bus.enable && !key_ready_q)  drop_q <= 1'b1;
    end

    assign bus.drop_err = drop_q;
`endif

endmodule

// File: tb/tb_aes_dec_full_pipeline.sv
// Directed testbench for aes_dec_full_pipeline using FIPS-197 known-answer
// vectors. Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_dec_full_pipeline;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_dec_full_pipeline_if bus ();

    aes_dec_full_pipeline dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_Z = 128'hc6a13b37878f5b826f4f8162a1c8d879;
    localparam logic [127:0] PT_Z = 128'h00000000000000000000000000000000;
    localparam logic [127:0] CT_F = 128'h3c441f32ce07822364d7a2990e50bb13;
    localparam logic [127:0] PT_F = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic test_reset();
        rst        = 1'b1;
        bus.IN     = '0;
        bus.KEY    = '0;
        bus.enable = 1'b0;
        bus.fsm_en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.OUT !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h want %h", bus.OUT, 128'h0);
        end
        n_checks++;
        if (bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", bus.valid_out);
        end
        n_checks++;
        if (bus.key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_key_ready: got %b want 0", bus.key_ready);
        end
`ifdef AES_DEC_DROP_FLAG_EN
        n_checks++;
        if (bus.drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop_err: got %b want 0", bus.drop_err);
        end
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_key_ready: got %b want 0", bus.key_ready);
        end
    endtask

    // Pulse captured at edge 1; key_ready must first read 1 after edge 12.
    task automatic test_key_expand();
        bus.KEY    = KEY1;
        bus.fsm_en = 1'b1;
        @(negedge clk);
        bus.fsm_en = 1'b0;
        bus.KEY    = ~KEY1;
        for (int k = 1; k <= 13; k++) begin
            n_checks++;
            if (bus.key_ready !== (k >= 12)) begin
                n_fail++;
                $display("FAIL key_ready_timing: after edge %0d got %b want %b",
                         k, bus.key_ready, (k >= 12));
            end
            @(negedge clk);
        end
    endtask

    // Captured at edge 1, visible after edge 11, held afterwards.
    task automatic test_single_block();
        bus.IN     = CT_A;
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        bus.IN     = CT_Z;
        for (int k = 1; k <= 13; k++) begin
            n_checks++;
            if (bus.valid_out !== (k == 11)) begin
                n_fail++;
                $display("FAIL single_valid: after edge %0d got %b want %b",
                         k, bus.valid_out, (k == 11));
            end
            if (k >= 11) begin
                n_checks++;
                if (bus.OUT !== PT_A) begin
                    n_fail++;
                    $display("FAIL single_out: after edge %0d got %h want %h", k, bus.OUT, PT_A);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] cts [11];
        logic [127:0] pts [11];
        int sel [11] = '{0, 1, 2, 0, 2, 1, 1, 0, 2, 2, 0};
        logic exp_v;
        for (int j = 0; j < 11; j++) begin
            case (sel[j])
                0:       begin cts[j] = CT_A; pts[j] = PT_A; end
                1:       begin cts[j] = CT_Z; pts[j] = PT_Z; end
                default: begin cts[j] = CT_F; pts[j] = PT_F; end
            endcase
        end
        for (int cyc = 0; cyc <= 23; cyc++) begin
            exp_v = (cyc >= 11) && (cyc <= 21);
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_valid: cycle %0d got %b want %b", cyc, bus.valid_out, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (bus.OUT !== pts[cyc-11]) begin
                    n_fail++;
                    $display("FAIL b2b_out: block %0d got %h want %h",
                             cyc - 11, bus.OUT, pts[cyc-11]);
                end
            end
            if (cyc < 11) begin
                bus.IN     = cts[cyc];
                bus.enable = 1'b1;
            end else begin
                bus.enable = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drop_before_ready();
        logic seen;
        bus.KEY    = KEY1;
        bus.fsm_en = 1'b1;
        @(negedge clk);
        bus.fsm_en = 1'b0;
`ifdef AES_DEC_DROP_FLAG_EN
        n_checks++;
        if (bus.drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_err_clear: got %b want 0", bus.drop_err);
        end
`endif
        bus.IN     = CT_A;
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (bus.valid_out) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_no_valid: got valid_out seen=%b want 0", seen);
        end
        n_checks++;
        if (bus.key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_key_ready: got %b want 1", bus.key_ready);
        end
`ifdef AES_DEC_DROP_FLAG_EN
        n_checks++;
        if (bus.drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_err_sticky: got %b want 1", bus.drop_err);
        end
`endif
    endtask

    task automatic test_rekey_in_flight();
        logic seen;
        int   wait_cnt;
        for (int j = 0; j < 5; j++) begin
            bus.IN     = CT_A;
            bus.enable = 1'b1;
            @(negedge clk);
        end
        bus.enable = 1'b0;
        bus.KEY    = KEY2;
        bus.fsm_en = 1'b1;
        @(negedge clk);
        bus.fsm_en = 1'b0;
        bus.KEY    = KEY1;
        seen       = 1'b0;
        wait_cnt   = 0;
        while (!bus.key_ready && wait_cnt < 40) begin
            if (bus.valid_out) seen = 1'b1;
            wait_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (bus.key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rekey_timeout: key_ready got %b want 1", bus.key_ready);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rekey_flush: in-flight valid seen=%b want 0", seen);
        end
        bus.IN     = CT_B;
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.valid_out) seen = 1'b1;
            if (k == 11) begin
                n_checks++;
                if (bus.valid_out !== 1'b1 || bus.OUT !== PT_B) begin
                    n_fail++;
                    $display("FAIL rekey_out: valid %b out %h want valid 1 out %h",
                             bus.valid_out, bus.OUT, PT_B);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stream();
        for (int j = 0; j < 12; j++) begin
            bus.IN     = CT_B;
            bus.enable = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.OUT !== PT_B) begin
            n_fail++;
            $display("FAIL midstream_pre: valid %b out %h want valid 1 out %h",
                     bus.valid_out, bus.OUT, PT_B);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.OUT !== 128'h0) begin
            n_fail++;
            $display("FAIL async_rst_out: got %h want %h", bus.OUT, 128'h0);
        end
        n_checks++;
        if (bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_valid: got %b want 0", bus.valid_out);
        end
        n_checks++;
        if (bus.key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_key_ready: got %b want 0", bus.key_ready);
        end
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.key_ready !== 1'b0 || bus.valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst_idle: key_ready %b valid %b want 0 0",
                         bus.key_ready, bus.valid_out);
            end
        end
    endtask

    task automatic test_recover();
        int wait_cnt;
        bus.KEY    = KEY1;
        bus.fsm_en = 1'b1;
        @(negedge clk);
        bus.fsm_en = 1'b0;
        wait_cnt   = 0;
        while (!bus.key_ready && wait_cnt < 40) begin
            wait_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (bus.key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL recover_timeout: key_ready got %b want 1", bus.key_ready);
        end
        bus.IN     = CT_Z;
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.OUT !== PT_Z) begin
            n_fail++;
            $display("FAIL recover_out: valid %b out %h want valid 1 out %h",
                     bus.valid_out, bus.OUT, PT_Z);
        end
    endtask

    initial begin
        test_reset();
        test_key_expand();
        test_single_block();
        test_back_to_back();
        test_drop_before_ready();
        test_rekey_in_flight();
        test_reset_mid_stream();
        test_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
